// File: rtl/lib_onehot_serializer.sv
// lib_onehot_serializer: accepts a frame of one-hot lanes and streams the
// bit index of each non-zero lane, lowest lane first, over valid/ready.
// An all-zero frame emits one beat flagged pos_none_o so every frame ends
// with a pos_last_o beat.

// Per-lane decode: non-zero flag, lowest set bit index, multi-bit flag.
module lib_onehot_serializer_lane #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] lane,
    output logic             nz,
    output logic [IDX_W-1:0] idx,
    output logic             multi
);

    // Lowest set bit wins; scanning downward lets the lowest overwrite last.
    always_comb begin
        idx = '0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            if (lane[b]) idx = IDX_W'(b);
        end
    end

    assign nz    = |lane;
    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign multi = |(lane & (lane - WIDTH'(1)));

endmodule

module lib_onehot_serializer #(
    parameter int WIDTH   = 16,
    parameter int FFS_NUM = WIDTH
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               vld_i,
    input  logic [WIDTH-1:0]                   onehot [FFS_NUM],
    output logic                               rdy_o,
    output logic                               pos_vld_o,
    input  logic                               pos_rdy_i,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] pos_o,
    output logic                               pos_last_o,
    output logic                               pos_none_o,
    output logic                               pos_err_o,
    output logic [$clog2(FFS_NUM+1)-1:0]       cnt_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(FFS_NUM + 1);

    // One-hot state encoding so rdy_o / pos_vld_o are straight flop outputs.
    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_EMIT = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]                lane_q   [FFS_NUM];
    logic [WIDTH-1:0]                src_lane [FFS_NUM];
    logic [FFS_NUM-1:0]              mask_q;
    logic [FFS_NUM-1:0]              src_mask;
    logic [FFS_NUM-1:0]              lane_nz;
    logic [FFS_NUM-1:0]              lane_multi;
    logic [FFS_NUM-1:0][IDX_W-1:0]   lane_idx;
    logic [FFS_NUM-1:0]              sel_oh;
    logic [IDX_W-1:0]                nxt_pos;
    logic                            nxt_err;
    logic                            nxt_last;
    logic                            nxt_none;
    logic [CNT_W-1:0]                nz_cnt;
    logic                            idle;
    logic                            accept;
    logic                            hs;

    assign idle   = (state_q == S_IDLE);
    assign accept = idle && vld_i;
    assign hs     = (state_q == S_EMIT) && pos_rdy_i;

    // Decode source: the incoming frame while idle, the stored frame while
    // emitting. One decoder bank serves both the first and later beats.
    always_comb begin
        for (int i = 0; i < FFS_NUM; i++) begin
            src_lane[i] = idle ? onehot[i] : lane_q[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FFS_NUM; gi++) begin : g_lane
            lib_onehot_serializer_lane #(
                .WIDTH (WIDTH),
                .IDX_W (IDX_W)
            ) u_lane (
                .lane  (src_lane[gi]),
                .nz    (lane_nz[gi]),
                .idx   (lane_idx[gi]),
                .multi (lane_multi[gi])
            );
        end
    endgenerate

    // Pending lanes for the next beat: a fresh mask when idle, otherwise the
    // stored mask with its lowest (currently presented) lane cleared.
    always_comb begin
        src_mask = idle ? lane_nz : (mask_q & (mask_q - FFS_NUM'(1)));
    end

    // Priority pick of the lowest pending lane and its encoded beat fields.
    always_comb begin
        sel_oh  = '0;
        nxt_pos = '0;
        nxt_err = 1'b0;
        for (int i = FFS_NUM - 1; i >= 0; i--) begin
            if (src_mask[i]) begin
                sel_oh      = '0;
                sel_oh[i]   = 1'b1;
                nxt_pos     = lane_idx[i];
                nxt_err     = lane_multi[i];
            end
        end
        nxt_none = (src_mask == '0);
        nxt_last = ((src_mask & ~sel_oh) == '0);
    end

    // Number of non-zero lanes in the incoming frame.
    always_comb begin
        nz_cnt = '0;
        for (int i = 0; i < FFS_NUM; i++) begin
            nz_cnt = nz_cnt + CNT_W'(lane_nz[i]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: accept moves to EMIT, the last handshaken beat returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (vld_i) state_d = S_EMIT;
            S_EMIT:  if (pos_rdy_i && pos_last_o) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode directly from the one-hot state flops.
    always_comb begin
        rdy_o     = state_q[0];
        pos_vld_o = state_q[1];
    end

    // Frame storage, pending mask and registered beat fields; beat fields
    // only change on accept or on a non-final handshake, so they hold under
    // backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FFS_NUM; i++) lane_q[i] <= '0;
            mask_q     <= '0;
            cnt_o      <= '0;
            pos_o      <= '0;
            pos_last_o <= 1'b0;
            pos_none_o <= 1'b0;
            pos_err_o  <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < FFS_NUM; i++) lane_q[i] <= onehot[i];
            mask_q     <= lane_nz;
            cnt_o      <= nz_cnt;
            pos_o      <= nxt_pos;
            pos_last_o <= nxt_last;
            pos_none_o <= nxt_none;
            pos_err_o  <= nxt_err;
        end else if (hs) begin
            mask_q <= src_mask;
            if (!pos_last_o) begin
                pos_o      <= nxt_pos;
                pos_last_o <= nxt_last;
                pos_none_o <= nxt_none;
                pos_err_o  <= nxt_err;
            end
        end
    end

endmodule

// File: tb/tb_lib_onehot_serializer.sv
// Directed bench for lib_onehot_serializer (WIDTH=16, FFS_NUM=4).
module tb_lib_onehot_serializer;

    localparam int WIDTH   = 16;
    localparam int FFS_NUM = 4;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 3;

    logic               clk;
    logic               rstn;
    logic               vld_i;
    logic [WIDTH-1:0]   onehot [FFS_NUM];
    logic               rdy_o;
    logic               pos_vld_o;
    logic               pos_rdy_i;
    logic [IDX_W-1:0]   pos_o;
    logic               pos_last_o;
    logic               pos_none_o;
    logic               pos_err_o;
    logic [CNT_W-1:0]   cnt_o;

    int errors = 0;
    int checks = 0;

    lib_onehot_serializer #(.WIDTH(WIDTH), .FFS_NUM(FFS_NUM)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .vld_i      (vld_i),
        .onehot     (onehot),
        .rdy_o      (rdy_o),
        .pos_vld_o  (pos_vld_o),
        .pos_rdy_i  (pos_rdy_i),
        .pos_o      (pos_o),
        .pos_last_o (pos_last_o),
        .pos_none_o (pos_none_o),
        .pos_err_o  (pos_err_o),
        .cnt_o      (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                             input logic [WIDTH-1:0] l2, input logic [WIDTH-1:0] l3);
        onehot[0] = l0; onehot[1] = l1; onehot[2] = l2; onehot[3] = l3;
    endtask

    // Present a frame, wait (bounded) for rdy_o, take the accept edge.
    // Leaves vld_i high when hold is set.
    task automatic send(input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                        input logic [WIDTH-1:0] l2, input logic [WIDTH-1:0] l3,
                        input bit hold);
        int n;
        set_frame(l0, l1, l2, l3);
        vld_i = 1'b1;
        n = 0;
        while (!rdy_o && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("rdy_timeout", 0, 1);
        tick();
        if (!hold) vld_i = 1'b0;
    endtask

    task automatic beat(input string tag, input int p, input int last, input int err,
                        input int none, input int cnt);
        chk({tag, "_vld"},  int'(pos_vld_o),  1);
        chk({tag, "_pos"},  int'(pos_o),      p);
        chk({tag, "_last"}, int'(pos_last_o), last);
        chk({tag, "_err"},  int'(pos_err_o),  err);
        chk({tag, "_none"}, int'(pos_none_o), none);
        chk({tag, "_cnt"},  int'(cnt_o),      cnt);
        chk({tag, "_rdy"},  int'(rdy_o),      0);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_rdy"}, int'(rdy_o),     1);
        chk({tag, "_vld"}, int'(pos_vld_o), 0);
    endtask

    int bp_rdy  [5] = '{1, 0, 0, 1, 1};
    int bp_pos  [5] = '{3, 8, 8, 8, 15};
    int bp_last [5] = '{0, 0, 0, 0, 1};

    initial begin
        rstn = 1'b0;
        vld_i = 1'b0;
        pos_rdy_i = 1'b1;
        set_frame('0, '0, '0, '0);
        #12;
        // Reset state
        chk("rst_rdy",  int'(rdy_o),      1);
        chk("rst_vld",  int'(pos_vld_o),  0);
        chk("rst_pos",  int'(pos_o),      0);
        chk("rst_last", int'(pos_last_o), 0);
        chk("rst_none", int'(pos_none_o), 0);
        chk("rst_err",  int'(pos_err_o),  0);
        chk("rst_cnt",  int'(cnt_o),      0);
        rstn = 1'b1;
        tick();
        idle_chk("idle0");

        // Basic frame, no backpressure
        send(16'h0008, 16'h0000, 16'h0100, 16'h8000, 1'b0);
        beat("b0", 3, 0, 0, 0, 3);
        tick();
        beat("b1", 8, 0, 0, 0, 3);
        tick();
        beat("b2", 15, 1, 0, 0, 3);
        tick();
        idle_chk("b_end");

        // Empty frame
        send(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        beat("e0", 0, 1, 0, 1, 0);
        tick();
        idle_chk("e_end");

        // Backpressure pattern 1,0,0,1,1
        send(16'h0008, 16'h0000, 16'h0100, 16'h8000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            pos_rdy_i = bp_rdy[k][0];
            beat($sformatf("bp%0d", k), bp_pos[k], bp_last[k], 0, 0, 3);
            tick();
        end
        pos_rdy_i = 1'b1;
        idle_chk("bp_end");

        // Multi-bit lane followed by a clean lane
        send(16'h0014, 16'h0001, 16'h0000, 16'h0000, 1'b0);
        beat("m0", 2, 0, 1, 0, 2);
        tick();
        beat("m1", 0, 1, 0, 0, 2);
        tick();
        idle_chk("m_end");

        // vld_i held through EMIT with new data: ignored until rdy_o
        send(16'h0008, 16'h0000, 16'h0100, 16'h8000, 1'b1);
        set_frame(16'h0002, 16'h0000, 16'h0000, 16'h0400);
        beat("h0", 3, 0, 0, 0, 3);
        tick();
        beat("h1", 8, 0, 0, 0, 3);
        tick();
        beat("h2", 15, 1, 0, 0, 3);
        tick();
        idle_chk("h_gap");
        tick();
        vld_i = 1'b0;
        beat("h3", 1, 0, 0, 0, 2);
        tick();
        beat("h4", 10, 1, 0, 0, 2);
        tick();
        idle_chk("h_end");

        // Reset asserted mid-frame
        pos_rdy_i = 1'b0;
        send(16'h0008, 16'h0000, 16'h0100, 16'h8000, 1'b0);
        beat("r0", 3, 0, 0, 0, 3);
        #2;
        rstn = 1'b0;
        #1;
        chk("r_async_vld", int'(pos_vld_o), 0);
        chk("r_async_rdy", int'(rdy_o),     1);
        chk("r_async_cnt", int'(cnt_o),     0);
        pos_rdy_i = 1'b1;
        tick();
        rstn = 1'b1;
        tick();
        idle_chk("r_post0");
        tick();
        idle_chk("r_post1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lib_onehot_serializer.md
Name: lib_onehot_serializer

Overview:
- Sits directly downstream of the one-hot decomposer stage. Accepts one frame per handshake: FFS_NUM one-hot lanes plus a frame valid.
- Registers the frame, then emits the binary bit index of each non-zero lane, one per cycle, with a valid/ready handshake and a last flag. Typical use: serialising error positions into a correction stage.
- An all-zero frame still produces one beat, flagged as empty, so every frame is terminated.

Parameters:
- WIDTH, 16, width of each one-hot lane; IDX_W = $clog2(WIDTH) is a derived localparam, minimum 1.
- FFS_NUM, WIDTH, number of input lanes; CNT_W = $clog2(FFS_NUM+1) is a derived localparam.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- vld_i  input  1  input frame valid.
- onehot  input  [WIDTH-1:0] x [FFS_NUM-1:0] (unpacked)  lane vectors; a zero lane means nothing was found in that lane.
- rdy_o  output  1  block can accept a frame.
- pos_vld_o  output  1  output beat valid.
- pos_rdy_i  input  1  downstream accepts beat.
- pos_o  output  IDX_W  bit index of the lowest set bit in the current lane.
- pos_last_o  output  1  final beat of the frame.
- pos_none_o  output  1  frame contained no non-zero lane; pos_o = 0.
- pos_err_o  output  1  current lane had more than one bit set.
- cnt_o  output  CNT_W  number of non-zero lanes in the current frame; held for the whole frame.

Behaviour:
- Reset (async, rstn=0): state IDLE, pending mask 0, rdy_o=1, pos_vld_o=0, pos_o=0, pos_last_o=0, pos_none_o=0, pos_err_o=0, cnt_o=0.
- Reset mid-frame: the frame in flight is dropped and all outputs return to their reset values immediately. No partial beats are emitted after rstn rises.
- IDLE:
  - rdy_o=1, pos_vld_o=0.
  - On vld_i & rdy_o: register all lanes, set pending mask bit i = |onehot[i], set cnt_o = popcount(mask), then go to EMIT.
  - vld_i while not in IDLE is ignored. Upstream must hold the frame until rdy_o=1.
- EMIT:
  - rdy_o=0, pos_vld_o=1. Latency is one cycle from the accept edge to the first pos_vld_o.
  - Current lane = lowest-index pending lane (ascending lane order).
  - pos_o = index of the lowest set bit of the current lane, independent of bit polarity conventions upstream.
  - pos_err_o=1 if the current lane's popcount > 1.
  - pos_last_o=1 when the current lane is the only pending lane.
  - Empty frame (mask=0): one beat with pos_none_o=1, pos_last_o=1, pos_o=0, cnt_o=0.
  - On pos_vld_o & pos_rdy_i: clear the current lane's mask bit. If pos_last_o, go to IDLE (rdy_o=1 the next cycle); otherwise present the next pending lane the next cycle.
  - pos_rdy_i=0: all pos_* outputs and cnt_o hold stable (AXI-style: valid does not drop, data does not change).
- Throughput: N non-zero lanes take N beats, plus 1 cycle back in IDLE before the next accept, i.e. N+1 cycles per frame minimum. Back-to-back frames without the bubble are not required.
- Outputs are registered. pos_rdy_i must have no combinational path to rdy_o.
- Priority selection and encoding are combinational over the registered lanes and must meet timing for FFS_NUM=WIDTH=16.

Test Plan:
- Reset then idle: rdy_o=1, all pos_* and cnt_o = 0. Assert rstn=0 during EMIT → pos_vld_o drops asynchronously; after release, rdy_o=1.
- WIDTH=16, FFS_NUM=4, lanes {0x0008, 0x0000, 0x0100, 0x8000}, pos_rdy_i=1 → beats pos_o=3, 8, 15 on consecutive cycles; cnt_o=3; pos_last_o only on the 15 beat; rdy_o=1 the cycle after.
- All lanes zero → single beat with pos_none_o=1, pos_last_o=1, pos_o=0, cnt_o=0.
- Backpressure: same frame as the second scenario, pos_rdy_i toggling 1,0,0,1,1 → the pos_o=8 beat holds for 3 cycles; sequence 3, 8, 15 is preserved with no drop or duplicate.
- Lane 0x0014 → pos_o=2, pos_err_o=1; the following clean lane 0x0001 → pos_o=0, pos_err_o=0.
- vld_i held high during EMIT with different data → ignored; the second frame is accepted only on the cycle rdy_o=1 and its beats follow the first frame's last beat.
